memory_pipeline_unit: RTL

// - MEM stage of the 5-stage ARM32 pipeline. Sits between the execute stage and the writeback stage, and feeds instr_out / wb_data_out to writeback.
// - Latches the EX instruction, ALU result and store data. Runs a req/ack data-memory access for LDR/STR.
// - Stalls upstream stages while an access is outstanding. Inserts NOP bubbles downstream during the stall.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/memory_pipeline_unit_idecoder.sv | 15 +
 rtl/memory_pipeline_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ARM32 pipeline constants, opcode classes and MEM-stage state type.
package cpu_pkg;
    localparam logic [31:0] NOP = 32'hE320F000;
    localparam logic [2:0] OPC_NOP   = 3'd0;
    localparam logic [2:0] OPC_DP    = 3'd1;
    localparam logic [2:0] OPC_LDR   = 3'd2;
    localparam logic [2:0] OPC_STR   = 3'd3;
    localparam logic [2:0] OPC_BR    = 3'd4;
    localparam logic [2:0] OPC_OTHER = 3'd5;
    typedef enum logic [0:0] {IDLE, ACCESS} mem_state_t;
endpackage

// File: rtl/memory_pipeline_unit_idecoder.sv
// idecoder: classifies an ARM32 instruction word into a coarse opcode class.
module idecoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  opcode_o
);
    // Single data transfer is bits[27:26]=01 with L (bit 20) selecting load vs store
    always_comb begin
        opcode_o = instr_i == NOP                ? OPC_NOP :
                   instr_i[27:26] == 2'b01       ? (instr_i[20] ? OPC_LDR : OPC_STR) :
                   instr_i[27:26] == 2'b00       ? OPC_DP :
                   instr_i[27:25] == 3'b101      ? OPC_BR : OPC_OTHER;
    end
endmodule

// File: rtl/memory_pipeline_unit.sv
// memory_pipeline_unit: MEM stage with req/ack data-memory access, upstream stall and NOP bubbles.
// Optional forwarding outputs (fwd_valid/fwd_rd/fwd_data) are built when MEM_FWD_EN is defined.
module memory_pipeline_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_out,
    output logic [31:0] instr_out,
    output logic [31:0] wb_data_out,
    output logic        mem_err
`ifdef MEM_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [3:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [31:0] instr_q, addr_q, sdata_q, instr_out_q, wb_q;
    logic [31:0] instr_out_d, wb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    mem_state_t st_q, st_d;
    logic [2:0] opc;
    logic is_ldr, is_str, timeout;

    idecoder u_dec (.instr_i(instr_q), .opcode_o(opc));

    assign is_ldr    = opc == OPC_LDR;
    assign is_str    = opc == OPC_STR;
    assign mem_req   = is_ldr | is_str;
    assign mem_we    = is_str;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = sdata_q;
    // cnt_q counts request cycles already spent unacked; the MAX_WAIT-th one times out
    assign timeout   = mem_req & ~mem_ack & (st_q == ACCESS ? cnt_q >= CW'(MAX_WAIT - 1) : MAX_WAIT == 1);
    // A timed-out access releases the stall in its last cycle so the next instruction enters
    assign stall_out = mem_req & ~mem_ack & ~timeout;

    assign instr_out   = instr_out_q;
    assign wb_data_out = wb_q;
    assign mem_err     = err_q;

    always_comb begin
        st_d        = (mem_req && !mem_ack && !timeout) ? ACCESS : IDLE;
        cnt_d       = st_d == ACCESS ? cnt_q + CW'(1) : '0;
        instr_out_d = (!mem_req || mem_ack) ? instr_q : NOP;
        wb_d        = !mem_req ? addr_q : !mem_ack ? wb_q : is_ldr ? mem_rdata : addr_q;
        err_d       = err_q | timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= NOP;
            addr_q      <= '0;
            sdata_q     <= '0;
            instr_out_q <= NOP;
            wb_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            st_q        <= IDLE;
        end else begin
            if (!stall_out) begin
                instr_q <= instr_in;
                addr_q  <= alu_result_in;
                sdata_q <= store_data_in;
            end
            instr_out_q <= instr_out_d;
            wb_q        <= wb_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            st_q        <= st_d;
        end
    end

`ifdef MEM_FWD_EN
    logic [2:0] out_opc;

    idecoder u_fwd_dec (.instr_i(instr_out_q), .opcode_o(out_opc));

    assign fwd_valid = out_opc == OPC_DP || out_opc == OPC_LDR;
    assign fwd_rd    = fwd_valid ? instr_out_q[15:12] : 4'd0;
    assign fwd_data  = wb_q;
`endif
endmodule
